// File: rtl/mem_refill_arbiter.sv
// Two-port line-refill arbiter for the shared main-memory refill port.
// Optional feature: define ARB_ROUND_ROBIN_EN for round-robin selection (default: port 0 fixed priority).
module mem_refill_arbiter #(
    parameter int unsigned ADR_WIDTH   = 32,
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned WORD_OFFSET = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req0_cc2arb,
    input  logic                   req1_cc2arb,
    input  logic [ADR_WIDTH-1:0]   adr0_cc2arb,
    input  logic [ADR_WIDTH-1:0]   adr1_cc2arb,
    output logic [1:0]             gnt_arb2cc,
    output logic                   ack0_arb2cc,
    output logic                   ack1_arb2cc,
    output logic [DATA_WIDTH-1:0]  dat_arb2cc,
    output logic [WORD_OFFSET-1:0] word_arb2cc,
    output logic                   req_arb2mem,
    output logic [ADR_WIDTH-1:0]   adr_arb2mem,
    input  logic                   ack_mem2arb,
    input  logic [DATA_WIDTH-1:0]  dat_mem2arb
);

    localparam int unsigned LINE_LSB = WORD_OFFSET + 2;
    localparam int unsigned TAG_W    = ADR_WIDTH - LINE_LSB;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] BURST   = 2'd1;
    localparam logic [1:0] RELEASE = 2'd2;

    logic [1:0]             state;
    logic [1:0]             state_nxt;
    logic [1:0]             gnt;
    logic [1:0]             gnt_nxt;
    logic                   req_mem;
    logic                   req_mem_nxt;
    logic [WORD_OFFSET-1:0] beat;
    logic [WORD_OFFSET-1:0] beat_nxt;
    logic [TAG_W-1:0]       adr_lat;
    logic [TAG_W-1:0]       adr_lat_nxt;
    logic                   sel_c;

    // Word-index and byte bits of the requester addresses are regenerated, never stored.
    logic unused_adr_bits;
    assign unused_adr_bits = ^{adr0_cc2arb[LINE_LSB-1:0], adr1_cc2arb[LINE_LSB-1:0]};

`ifdef ARB_ROUND_ROBIN_EN
    logic ptr;
    logic ptr_nxt;

    // Favoured port wins a tie; a lone requester always wins.
    always_comb begin
        if (req0_cc2arb && req1_cc2arb) begin
            sel_c = ptr;
        end else begin
            sel_c = !req0_cc2arb;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else begin
            ptr <= ptr_nxt;
        end
    end
`else
    // Port 0 always wins.
    always_comb begin
        sel_c = !req0_cc2arb;
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt     <= 2'b00;
            req_mem <= 1'b0;
            beat    <= '0;
            adr_lat <= '0;
        end else begin
            state   <= state_nxt;
            gnt     <= gnt_nxt;
            req_mem <= req_mem_nxt;
            beat    <= beat_nxt;
            adr_lat <= adr_lat_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        gnt_nxt     = gnt;
        req_mem_nxt = req_mem;
        beat_nxt    = beat;
        adr_lat_nxt = adr_lat;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_nxt     = ptr;
`endif
        case (state)
            IDLE: begin
                if (req0_cc2arb || req1_cc2arb) begin
                    state_nxt   = BURST;
                    gnt_nxt     = sel_c ? 2'b10 : 2'b01;
                    req_mem_nxt = 1'b1;
                    beat_nxt    = '0;
                    adr_lat_nxt = sel_c ? adr1_cc2arb[ADR_WIDTH-1:LINE_LSB]
                                        : adr0_cc2arb[ADR_WIDTH-1:LINE_LSB];
                end
            end
            BURST: begin
                // Counter wraps to zero on the last beat, ready for the next burst.
                if (ack_mem2arb) begin
                    beat_nxt = beat + WORD_OFFSET'(1);
                    if (&beat) begin
                        state_nxt   = RELEASE;
                        gnt_nxt     = 2'b00;
                        req_mem_nxt = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
                        ptr_nxt     = !gnt[1];
`endif
                    end
                end
            end
            RELEASE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt   = IDLE;
                gnt_nxt     = 2'b00;
                req_mem_nxt = 1'b0;
                beat_nxt    = '0;
            end
        endcase
    end

    // Zero-latency steering of the memory return to the granted controller.
    assign ack0_arb2cc = ack_mem2arb & gnt[0];
    assign ack1_arb2cc = ack_mem2arb & gnt[1];
    assign dat_arb2cc  = dat_mem2arb;
    assign word_arb2cc = beat;
    assign gnt_arb2cc  = gnt;
    assign req_arb2mem = req_mem;
    assign adr_arb2mem = {adr_lat, beat, 2'b00};

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Self-checking bench for mem_refill_arbiter: directed scenarios plus randomized bursts
// checked against a transaction-level model of grants, addresses and steering.
module tb_mem_refill_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_cc2arb, req1_cc2arb;
    logic [31:0] adr0_cc2arb, adr1_cc2arb;
    logic [1:0]  gnt_arb2cc;
    logic        ack0_arb2cc, ack1_arb2cc;
    logic [31:0] dat_arb2cc;
    logic [1:0]  word_arb2cc;
    logic        req_arb2mem;
    logic [31:0] adr_arb2mem;
    logic        ack_mem2arb;
    logic [31:0] dat_mem2arb;

    int tests = 0;
    int fails = 0;
    int exp_ptr = 0;

    mem_refill_arbiter dut (
        .clk(clk), .rst(rst),
        .req0_cc2arb(req0_cc2arb), .req1_cc2arb(req1_cc2arb),
        .adr0_cc2arb(adr0_cc2arb), .adr1_cc2arb(adr1_cc2arb),
        .gnt_arb2cc(gnt_arb2cc), .ack0_arb2cc(ack0_arb2cc), .ack1_arb2cc(ack1_arb2cc),
        .dat_arb2cc(dat_arb2cc), .word_arb2cc(word_arb2cc),
        .req_arb2mem(req_arb2mem), .adr_arb2mem(adr_arb2mem),
        .ack_mem2arb(ack_mem2arb), .dat_mem2arb(dat_mem2arb)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, time=%0t required=<2000000", $time);
        $fatal(1);
    end

    // Selection rule: tie goes to favoured port (round robin) or port 0 (fixed).
    function automatic int pick(input bit r0, input bit r1);
`ifdef ARB_ROUND_ROBIN_EN
        if (r0 && r1) return exp_ptr;
`endif
        return r0 ? 0 : 1;
    endfunction

    task automatic do_reset;
        @(posedge clk); #1;
        rst = 1'b1; req0_cc2arb = 1'b0; req1_cc2arb = 1'b0; ack_mem2arb = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_ptr = 0;
    endtask

    task automatic wait_grant(input int win);
        logic [1:0] eg;
        int n;
        eg = (win == 1) ? 2'b10 : 2'b01;
        n = 0;
        while (gnt_arb2cc == 2'b00 && n < 20) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (gnt_arb2cc !== eg) begin
            fails++;
            $display("FAIL grant: got %b required %b (waited %0d)", gnt_arb2cc, eg, n);
        end
        tests++;
        if (req_arb2mem !== 1'b1) begin
            fails++;
            $display("FAIL mem_req_in_burst: got %b required 1", req_arb2mem);
        end
    endtask

    // Drives one burst for winner 'win' and checks steering, addresses and release.
    task automatic run_burst(input int win, input logic [31:0] base, input int min_gap,
                             input int max_gap, input int drop_at, input int n_acks,
                             input logic [1:0] drop_end, input bit stray_rel, input bit scramble);
        logic [31:0] ea;
        logic [31:0] d;
        int g;
        for (int k = 0; k < n_acks; k++) begin
            g = $urandom_range(max_gap, min_gap);
            for (int i = 0; i < g; i++) begin
                @(posedge clk); #1;
                ack_mem2arb = 1'b0;
                @(negedge clk);
                tests++;
                if ({ack0_arb2cc, ack1_arb2cc} !== 2'b00) begin
                    fails++;
                    $display("FAIL idle_gap_ack: got %b%b required 00", ack0_arb2cc, ack1_arb2cc);
                end
            end
            @(posedge clk); #1;
            d = $urandom();
            ack_mem2arb = 1'b1;
            dat_mem2arb = d;
            if (scramble) begin
                adr0_cc2arb = $urandom();
                adr1_cc2arb = $urandom();
            end
            @(negedge clk);
            ea = {base[31:4], 2'(k), 2'b00};
            tests++;
            if (adr_arb2mem !== ea) begin
                fails++;
                $display("FAIL mem_adr beat %0d: got %h required %h", k, adr_arb2mem, ea);
            end
            tests++;
            if (word_arb2cc !== 2'(k)) begin
                fails++;
                $display("FAIL word_idx: got %0d required %0d", word_arb2cc, k);
            end
            tests++;
            if (ack0_arb2cc !== (win == 0) || ack1_arb2cc !== (win == 1)) begin
                fails++;
                $display("FAIL ack_route beat %0d: got ack0=%b ack1=%b required port %0d",
                         k, ack0_arb2cc, ack1_arb2cc, win);
            end
            tests++;
            if (dat_arb2cc !== d) begin
                fails++;
                $display("FAIL data: got %h required %h", dat_arb2cc, d);
            end
            if (k + 1 == drop_at) begin
                @(posedge clk); #1;
                ack_mem2arb = 1'b0;
                if (win == 0) req0_cc2arb = 1'b0; else req1_cc2arb = 1'b0;
                @(negedge clk);
                tests++;
                if (gnt_arb2cc !== ((win == 1) ? 2'b10 : 2'b01)) begin
                    fails++;
                    $display("FAIL grant_after_drop: got %b required port %0d", gnt_arb2cc, win);
                end
            end
        end
        if (n_acks < 4) return;
        // RELEASE cycle
        @(posedge clk); #1;
        ack_mem2arb = stray_rel;
        if (drop_end[0]) req0_cc2arb = 1'b0;
        if (drop_end[1]) req1_cc2arb = 1'b0;
        @(negedge clk);
        tests++;
        if (req_arb2mem !== 1'b0 || gnt_arb2cc !== 2'b00) begin
            fails++;
            $display("FAIL release: got req=%b gnt=%b required 0/00", req_arb2mem, gnt_arb2cc);
        end
        tests++;
        if ({ack0_arb2cc, ack1_arb2cc} !== 2'b00 || word_arb2cc !== 2'd0) begin
            fails++;
            $display("FAIL release_ack: got ack=%b%b word=%0d required 00/0",
                     ack0_arb2cc, ack1_arb2cc, word_arb2cc);
        end
        exp_ptr = 1 - win;
        // IDLE cycle
        @(posedge clk); #1;
        ack_mem2arb = 1'b0;
        @(negedge clk);
        tests++;
        if (req_arb2mem !== 1'b0 || gnt_arb2cc !== 2'b00 || word_arb2cc !== 2'd0) begin
            fails++;
            $display("FAIL idle_after_release: got req=%b gnt=%b word=%0d required 0/00/0",
                     req_arb2mem, gnt_arb2cc, word_arb2cc);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; req0_cc2arb = 1'b0; req1_cc2arb = 1'b0; ack_mem2arb = 1'b0;
        adr0_cc2arb = '0; adr1_cc2arb = '0; dat_mem2arb = '0;
        @(negedge clk);
        tests++;
        if ({gnt_arb2cc, req_arb2mem, ack0_arb2cc, ack1_arb2cc, word_arb2cc} !== 7'd0
            || adr_arb2mem !== 32'd0) begin
            fails++;
            $display("FAIL reset_state: got gnt=%b req=%b ack=%b%b word=%0d adr=%h required zeros",
                     gnt_arb2cc, req_arb2mem, ack0_arb2cc, ack1_arb2cc, word_arb2cc, adr_arb2mem);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_single;
        @(posedge clk); #1;
        adr0_cc2arb = 32'hFF07BD08;
        req0_cc2arb = 1'b1;
        @(negedge clk);
        tests++;
        if (gnt_arb2cc !== 2'b00) begin
            fails++;
            $display("FAIL grant_latency_early: got %b required 00", gnt_arb2cc);
        end
        @(negedge clk);
        tests++;
        if (gnt_arb2cc !== 2'b01 || req_arb2mem !== 1'b1) begin
            fails++;
            $display("FAIL grant_latency: got gnt=%b req=%b required 01/1", gnt_arb2cc, req_arb2mem);
        end
        run_burst(0, 32'hFF07BD08, 1, 1, -1, 4, 2'b01, 1'b0, 1'b0);
    endtask

    task automatic test_simultaneous;
        int w;
        do_reset();
        adr0_cc2arb = 32'hA5552D08;
        adr1_cc2arb = 32'hD500AD08;
        req0_cc2arb = 1'b1;
        req1_cc2arb = 1'b1;
        for (int b = 0; b < 3; b++) begin
            w = pick(1'b1, 1'b1);
            wait_grant(w);
            run_burst(w, (w == 1) ? 32'hD500AD08 : 32'hA5552D08, 0, 2, -1, 4,
                      (b == 2) ? 2'b01 : 2'b00, 1'b0, 1'b0);
        end
        w = pick(1'b0, 1'b1);
        wait_grant(w);
        run_burst(w, 32'hD500AD08, 0, 2, -1, 4, 2'b10, 1'b0, 1'b0);
    endtask

    task automatic test_drop_mid;
        logic [31:0] a;
        a = $urandom();
        @(posedge clk); #1;
        adr1_cc2arb = a;
        req1_cc2arb = 1'b1;
        wait_grant(pick(1'b0, 1'b1));
        run_burst(1, a, 0, 2, 2, 4, 2'b10, 1'b0, 1'b1);
    endtask

    task automatic test_reset_mid;
        logic [31:0] a;
        a = $urandom();
        @(posedge clk); #1;
        adr0_cc2arb = a;
        req0_cc2arb = 1'b1;
        wait_grant(pick(1'b1, 1'b0));
        run_burst(0, a, 0, 1, -1, 2, 2'b00, 1'b0, 1'b0);
        @(posedge clk); #2;
        ack_mem2arb = 1'b1;
        req0_cc2arb = 1'b0;
        rst = 1'b1;
        #1;
        tests++;
        if ({gnt_arb2cc, req_arb2mem, ack0_arb2cc, ack1_arb2cc, word_arb2cc} !== 7'd0
            || adr_arb2mem !== 32'd0) begin
            fails++;
            $display("FAIL async_reset: got gnt=%b req=%b ack=%b%b word=%0d adr=%h required zeros",
                     gnt_arb2cc, req_arb2mem, ack0_arb2cc, ack1_arb2cc, word_arb2cc, adr_arb2mem);
        end
        @(posedge clk); #1;
        ack_mem2arb = 1'b0;
        rst = 1'b0;
        exp_ptr = 0;
        @(posedge clk); #1;
        ack_mem2arb = 1'b1;
        @(negedge clk);
        tests++;
        if ({ack0_arb2cc, ack1_arb2cc} !== 2'b00) begin
            fails++;
            $display("FAIL stray_ack_idle: got %b%b required 00", ack0_arb2cc, ack1_arb2cc);
        end
        @(posedge clk); #1;
        ack_mem2arb = 1'b0;
        @(negedge clk);
        tests++;
        if (word_arb2cc !== 2'd0 || req_arb2mem !== 1'b0) begin
            fails++;
            $display("FAIL stray_ack_counter: got word=%0d req=%b required 0/0", word_arb2cc, req_arb2mem);
        end
        a = $urandom();
        @(posedge clk); #1;
        adr1_cc2arb = a;
        req1_cc2arb = 1'b1;
        wait_grant(pick(1'b0, 1'b1));
        run_burst(1, a, 0, 2, -1, 4, 2'b10, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back;
        logic [31:0] a;
        a = $urandom();
        @(posedge clk); #1;
        adr0_cc2arb = a;
        req0_cc2arb = 1'b1;
        wait_grant(pick(1'b1, 1'b0));
        run_burst(0, a, 0, 0, -1, 4, 2'b01, 1'b1, 1'b0);
    endtask

    task automatic test_random;
        bit r0, r1;
        int w;
        logic [31:0] a0, a1;
        for (int it = 0; it < 8; it++) begin
            r0 = 1'($urandom_range(1, 0));
            r1 = 1'($urandom_range(1, 0));
            if (!r0 && !r1) r1 = 1'b1;
            a0 = $urandom();
            a1 = $urandom();
            @(posedge clk); #1;
            adr0_cc2arb = a0;
            adr1_cc2arb = a1;
            req0_cc2arb = r0;
            req1_cc2arb = r1;
            w = pick(r0, r1);
            wait_grant(w);
            run_burst(w, (w == 1) ? a1 : a0, 0, 3, -1, 4, 2'b11, 1'b0, 1'b1);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_drop_mid();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
